// File: rtl/neander_mem_pkg.sv
// Shared constants, FSM state type and helpers for the Neander 16x8 word memory.
// Build option MEM_INIT_EN: reset loads word i with i instead of 0x00.
package neander_mem_pkg;

    localparam int MEM_WORDS = 16;
    localparam int MEM_AW    = 4;
    localparam int MEM_DW    = 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    // One-hot word select derived from the address register.
    function automatic logic [MEM_WORDS-1:0] addr_decode(input logic [MEM_AW-1:0] a);
        logic [MEM_WORDS-1:0] sel;
        sel    = {MEM_WORDS{1'b0}};
        sel[a] = 1'b1;
        return sel;
    endfunction

    // Reset contents of word i.
    function automatic logic [MEM_DW-1:0] word_rst_val(input int unsigned i);
        logic [MEM_AW-1:0] idx;
        idx = i[MEM_AW-1:0];
`ifdef MEM_INIT_EN
        return {4'h0, idx};
`else
        return (idx == 4'h0) ? 8'h00 : 8'h00;
`endif
    endfunction

endpackage

// File: rtl/neander_mem16_if.sv
// Request/response bus between a Neander-style CPU and its 16-word memory block.
interface neander_mem16_if;
    logic                               req;
    logic                               we;
    logic [neander_mem_pkg::MEM_AW-1:0] addr;
    logic [neander_mem_pkg::MEM_DW-1:0] wdata;
    logic                               ready;
    logic                               done;
    logic [neander_mem_pkg::MEM_DW-1:0] rdata;
    logic [neander_mem_pkg::MEM_AW-1:0] rem_q;

    modport master (output req, we, addr, wdata, input ready, done, rdata, rem_q);
    modport slave  (input req, we, addr, wdata, output ready, done, rdata, rem_q);
endinterface

// File: rtl/neander_mem16_chk.sv
// Structural invariants of neander_mem16: word select one-hot, handshake flags track FSM state.
module neander_mem16_chk
    import neander_mem_pkg::*;
(
    input logic                 clk,
    input logic                 rst_n,
    input logic [MEM_WORDS-1:0] word_we,
    input state_t               state,
    input logic                 ready,
    input logic                 done
);

    a_sel_onehot0: assert property (@(posedge clk) disable iff (!rst_n) $onehot0(word_we));
    a_we_in_access: assert property (@(posedge clk) disable iff (!rst_n)
        (word_we != {MEM_WORDS{1'b0}}) |-> (state == ACCESS));
    a_ready_idle: assert property (@(posedge clk) disable iff (!rst_n) ready == (state == IDLE));
    a_done_state: assert property (@(posedge clk) disable iff (!rst_n) done == (state == DONE));

endmodule

// File: rtl/neander_mem16_word.sv
// Single 8-bit storage word with write enable and a per-instance reset value.
module mem_word #(
    parameter logic [7:0] RST_VAL = 8'h00
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       we,
    input  logic [7:0] d,
    output logic [7:0] q
);

    logic [7:0] q_r;

    // Word storage; loads d only when selected for a write.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_r <= RST_VAL;
        end else if (we) begin
            q_r <= d;
        end
    end

    assign q = q_r;

endmodule

// File: rtl/neander_mem16.sv
// Neander 16x8 memory block: REM/RDM registers, 3-state access FSM, 16 mem_word instances.
// Build option MEM_INIT_EN selects the reset contents (see neander_mem_pkg::word_rst_val).
module neander_mem16
    import neander_mem_pkg::*;
(
    input logic               clk,
    input logic               rst_n,
    neander_mem16_if.slave    bus
);

    state_t               state_r;
    state_t               state_nx_s;
    logic                 ready_r;
    logic                 done_r;
    logic [MEM_AW-1:0]    rem_r;
    logic [MEM_DW-1:0]    rdm_r;
    logic                 op_r;
    logic [MEM_WORDS-1:0] word_we_s;
    logic [MEM_DW-1:0]    word_q_s [MEM_WORDS];
    logic [MEM_DW-1:0]    rd_word_s;

    // Next-state logic; requests are only looked at while idle.
    always_comb begin
        state_nx_s = state_r;
        case (state_r)
            IDLE: begin
                if (bus.req) begin
                    state_nx_s = ACCESS;
                end else begin
                    state_nx_s = IDLE;
                end
            end
            ACCESS:  state_nx_s = DONE;
            DONE:    state_nx_s = IDLE;
            default: state_nx_s = IDLE;
        endcase
    end

    // State register; ready/done are registered from the next state so they match the state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
            ready_r <= 1'b1;
            done_r  <= 1'b0;
        end else begin
            state_r <= state_nx_s;
            ready_r <= (state_nx_s == IDLE);
            done_r  <= (state_nx_s == DONE);
        end
    end

    // REM/RDM/op datapath: capture on accept, RDM reload on read access.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rem_r <= 4'h0;
            rdm_r <= 8'h00;
            op_r  <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (bus.req) begin
                        rem_r <= bus.addr;
                        op_r  <= bus.we;
                        if (bus.we) begin
                            rdm_r <= bus.wdata;
                        end
                    end
                end
                ACCESS: begin
                    if (!op_r) begin
                        rdm_r <= rd_word_s;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Write strobe is gated to the ACCESS state of a write; RDM is the write data.
    always_comb begin
        word_we_s = {MEM_WORDS{1'b0}};
        if ((state_r == ACCESS) && op_r) begin
            word_we_s = addr_decode(rem_r);
        end else begin
            word_we_s = {MEM_WORDS{1'b0}};
        end
    end

    // Read mux addressed by REM.
    always_comb begin
        rd_word_s = word_q_s[rem_r];
    end

    for (genvar g = 0; g < MEM_WORDS; g++) begin : g_word
        mem_word #(
            .RST_VAL (word_rst_val(g))
        ) u_word (
            .clk   (clk),
            .rst_n (rst_n),
            .we    (word_we_s[g]),
            .d     (rdm_r),
            .q     (word_q_s[g])
        );
    end

    neander_mem16_chk u_chk (
        .clk     (clk),
        .rst_n   (rst_n),
        .word_we (word_we_s),
        .state   (state_r),
        .ready   (ready_r),
        .done    (done_r)
    );

    assign bus.ready = ready_r;
    assign bus.done  = done_r;
    assign bus.rdata = rdm_r;
    assign bus.rem_q = rem_r;

endmodule

// File: tb/tb_neander_mem16.sv
// Self-checking bench for neander_mem16: directed vector table, corner sequences, random vs. array model.
module tb_neander_mem16;

    logic clk = 1'b0;
    logic rst_n;
    int   n_cmp = 0;
    int   n_err = 0;

    logic [7:0] mem_m [16];

    typedef struct {
        logic       we;
        logic [3:0] addr;
        logic [7:0] wdata;
        logic [7:0] exp;
        string      name;
    } vec_t;

    vec_t vecs [7];

    neander_mem16_if bus ();

    neander_mem16 dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] rst_val(input int i);
`ifdef MEM_INIT_EN
        return 8'(i);
`else
        return (i < 0) ? 8'hFF : 8'h00;
`endif
    endfunction

    task automatic check(input string nm, input logic [7:0] act, input logic [7:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%02h expected 0x%02h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 16; i++) mem_m[i] = rst_val(i);
    endtask

    // Starts and ends at a negedge in IDLE; one access takes exactly three clocks.
    task automatic access(input logic w, input logic [3:0] a, input logic [7:0] d,
                          input logic [7:0] exp, input string nm);
        check({nm, ".ready_idle"}, {7'd0, bus.ready}, 8'd1);
        bus.req = 1'b1; bus.we = w; bus.addr = a; bus.wdata = d;
        @(posedge clk); #1;
        bus.req = 1'b0; bus.we = 1'b0; bus.addr = 4'h0; bus.wdata = 8'h00;
        @(negedge clk);
        check({nm, ".done_access"}, {7'd0, bus.done}, 8'd0);
        check({nm, ".ready_access"}, {7'd0, bus.ready}, 8'd0);
        @(negedge clk);
        check({nm, ".done"}, {7'd0, bus.done}, 8'd1);
        check({nm, ".rdata"}, bus.rdata, exp);
        check({nm, ".rem_q"}, {4'h0, bus.rem_q}, {4'h0, a});
        if (w) mem_m[a] = d;
        @(negedge clk);
        check({nm, ".rdata_hold"}, bus.rdata, exp);
    endtask

    initial begin
        int dones;
        logic       w;
        logic [3:0] a;
        logic [7:0] d;
        logic [7:0] e;

        rst_n = 1'b0;
        bus.req = 1'b0; bus.we = 1'b0; bus.addr = 4'h0; bus.wdata = 8'h00;
        model_reset();
        @(negedge clk); @(negedge clk);
        check("rst.ready", {7'd0, bus.ready}, 8'd1);
        check("rst.done", {7'd0, bus.done}, 8'd0);
        check("rst.rdata", bus.rdata, 8'h00);
        check("rst.rem_q", {4'h0, bus.rem_q}, 8'h00);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 16; i++) access(1'b0, 4'(i), 8'h00, rst_val(i), "rst_read");

        vecs[0] = '{1'b1, 4'd3,  8'hA5, 8'hA5,       "wr3"};
        vecs[1] = '{1'b0, 4'd3,  8'h00, 8'hA5,       "rd3"};
        vecs[2] = '{1'b0, 4'd2,  8'h77, rst_val(2),  "rd2"};
        vecs[3] = '{1'b0, 4'd4,  8'h77, rst_val(4),  "rd4"};
        vecs[4] = '{1'b1, 4'd15, 8'h5A, 8'h5A,       "wr15"};
        vecs[5] = '{1'b0, 4'd15, 8'h00, 8'h5A,       "rd15_b2b"};
        vecs[6] = '{1'b0, 4'd3,  8'h00, 8'hA5,       "rd3_again"};
        for (int i = 0; i < 7; i++) access(vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].exp, vecs[i].name);

        // Request held through a read's ACCESS/DONE: only one follow-on write.
        dones = 0;
        bus.req = 1'b1; bus.we = 1'b0; bus.addr = 4'd0; bus.wdata = 8'h00;
        @(posedge clk); #1;
        bus.we = 1'b1; bus.addr = 4'd7; bus.wdata = 8'hFF;
        @(negedge clk); dones += int'(bus.done);
        @(negedge clk); dones += int'(bus.done);
        check("ign.rdata", bus.rdata, mem_m[0]);
        check("ign.rem_q", {4'h0, bus.rem_q}, 8'h00);
        @(negedge clk);
        check("ign.ready", {7'd0, bus.ready}, 8'd1);
        @(posedge clk); #1;
        bus.req = 1'b0; bus.we = 1'b0;
        @(negedge clk); dones += int'(bus.done);
        @(negedge clk); dones += int'(bus.done);
        check("ign.wr_rdata", bus.rdata, 8'hFF);
        check("ign.wr_rem_q", {4'h0, bus.rem_q}, 8'h07);
        mem_m[7] = 8'hFF;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk); dones += int'(bus.done);
        end
        check("ign.done_count", 8'(dones), 8'd2);
        access(1'b0, 4'd7, 8'h00, 8'hFF, "rd7");

        // Reset during ACCESS of a write.
        bus.req = 1'b1; bus.we = 1'b1; bus.addr = 4'd9; bus.wdata = 8'h3C;
        @(posedge clk); #1;
        bus.req = 1'b0; bus.we = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midrst.ready", {7'd0, bus.ready}, 8'd1);
        check("midrst.done", {7'd0, bus.done}, 8'd0);
        check("midrst.rdata", bus.rdata, 8'h00);
        check("midrst.rem_q", {4'h0, bus.rem_q}, 8'h00);
        model_reset();
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;
        dones = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); dones += int'(bus.done);
        end
        check("midrst.no_done", 8'(dones), 8'd0);
        access(1'b0, 4'd9, 8'h00, rst_val(9), "midrst.rd9");
        access(1'b0, 4'd15, 8'h00, rst_val(15), "midrst.rd15");

        for (int i = 0; i < 16; i++) access(1'b1, 4'(i), ~8'(i), ~8'(i), "sweep_wr");
        for (int i = 0; i < 16; i++) access(1'b0, 4'(i), 8'h00, ~8'(i), "sweep_rd");

        for (int k = 0; k < 60; k++) begin
            w = 1'($urandom_range(0, 1));
            a = 4'($urandom_range(0, 15));
            d = 8'($urandom);
            e = w ? d : mem_m[a];
            access(w, a, d, e, "rand");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/neander_mem16.md
NEANDER_MEM16 -- requirements
Module: neander_mem16

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-002 SHALL have port rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-003 SHALL have port req, input, 1 bit: access request, sampled only while ready=1.
REQ-004 SHALL have port we, input, 1 bit: 1=write, 0=read, sampled with req.
REQ-005 SHALL have port addr, input, 4 bits: word address 0..15, sampled with req.
REQ-006 SHALL have port wdata, input, 8 bits: write data, sampled with req when we=1.
REQ-007 SHALL have port ready, output, 1 bit: block idle, accepting a request.
REQ-008 SHALL have port done, output, 1 bit: one-cycle completion pulse.
REQ-009 SHALL have port rdata, output, 8 bits: continuous copy of data register RDM.
REQ-010 SHALL have port rem_q, output, 4 bits: continuous copy of address register REM.

Function
REQ-011 SHALL hold 16 words x 8 bits of storage, one word register per address.
REQ-012 SHALL implement FSM states IDLE, ACCESS, DONE; ready=1 only in IDLE; done=1 only in DONE.
REQ-013 SHALL, in IDLE with req=1, load REM<=addr, latch op<=we, load RDM<=wdata if we=1, and go to ACCESS; with req=0, stay in IDLE with REM/RDM unchanged.
REQ-014 SHALL, in ACCESS, write mem[REM]<=RDM if op=write, else load RDM<=mem[REM]; then go to DONE.
REQ-015 SHALL, in DONE, go unconditionally to IDLE.
REQ-016 SHALL select the word through a one-hot 16-bit decode of REM; exactly one word is enabled per write, none outside ACCESS.
REQ-017 SHALL have fixed latency: request accepted at edge N, done high during cycle N+2, rdata valid from cycle N+2 until the next accepted request.
REQ-018 SHALL ignore req, we, addr, wdata in ACCESS and DONE; no queuing; throughput is one access per 3 cycles.
REQ-019 SHALL accept a req present in the cycle after DONE (back-to-back) with no extra idle cycle.
REQ-020 SHALL return newly written data on a read issued right after a write to the same address.
REQ-021 SHALL keep RDM unchanged by a write's ACCESS state; RDM holds the written value after a write.

Reset
REQ-022 SHALL, on rst_n=0 in any state, asynchronously force FSM=IDLE, REM=0, RDM=0, op=read, ready=1, done=0.
REQ-023 SHALL, on reset, clear all 16 words to 0x00 (see REQ-025).
REQ-024 SHALL abort any access in flight when reset is asserted mid-operation; no partial write survives, and no done pulse follows reset release.

Configuration
REQ-025 SHALL support macro MEM_INIT_EN: when defined, reset loads word i with value {4'h0,i} (0x00..0x0F); when undefined, all words reset to 0x00.
REQ-026 SHALL keep the interface and timing identical with and without MEM_INIT_EN.

Structure
REQ-027 SHALL place in shared package neander_mem_pkg: constants MEM_WORDS=16, MEM_AW=4, MEM_DW=8, and the FSM state enum (IDLE, ACCESS, DONE).
REQ-028 SHALL use one sub-module, mem_word: 8-bit register with async active-low reset, reset value parameter, and write enable; instantiated 16 times.

Verification
REQ-029 Reset: assert rst_n=0 -> ready=1, done=0, rdata=0x00, rem_q=0; reads of all 16 addresses return 0x00 (0x00..0x0F with MEM_INIT_EN).
REQ-030 Write/read: write 0xA5 to addr 3 at edge N -> done at N+2; read addr 3 -> rdata=0xA5 with done; addr 2 and addr 4 unchanged.
REQ-031 Back-to-back: write 0x5A to addr 15, then read addr 15 in the cycle after done -> accepted immediately, rdata=0x5A three cycles later.
REQ-032 Ignored request: hold req=1, we=1, addr=7, wdata=0xFF through ACCESS/DONE of a read to addr 0 -> exactly one extra access (the write) begins after IDLE; done pulses once per access.
REQ-033 Reset mid-op: accept write 0x3C to addr 9, assert rst_n=0 during ACCESS -> no done; reading addr 9 after release returns its reset value.
REQ-034 Full sweep: write ~i to every addr i, then read all 16 -> each returns ~i; one-hot select is never multi-hot (assertion).
